// File: rtl/picorv_bus_fabric.sv
// PicoRV32 bus fabric: decodes mem_la_addr into N_SLAVES channels, runs fast or
// req/ack handshakes, muxes read data, and reports unmapped/timeout bus errors.
module picorv_bus_fabric #(
  parameter int unsigned          N_SLAVES       = 6,
  parameter int unsigned          SEL_LSB        = 28,
  parameter int unsigned          BASE_SEL       = 1,
  parameter logic [N_SLAVES-1:0]  FAST_MASK      = 6'b001111,
  parameter int unsigned          TIMEOUT_CYCLES = 1024,
  parameter logic [31:0]          ERROR_DATA     = 32'hDEADBEEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     mem_valid,
  input  logic [31:0]              mem_la_addr,
  output logic                     mem_ready,
  output logic [31:0]              mem_rdata,
  output logic [N_SLAVES-1:0]      slave_req,
  input  logic [N_SLAVES-1:0]      slave_ack,
  input  logic [32*N_SLAVES-1:0]   slave_rdata,
  output logic                     bus_error,
  output logic [31:0]              err_addr,
  output logic [7:0]               err_count
);

  localparam int unsigned SEL_W = 32 - SEL_LSB;
  localparam int unsigned IDX_W = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  state_t             state, state_next;
  logic [IDX_W-1:0]   idx_q, idx_next, idx_new;
  logic [31:0]        addr_q, addr_next;
  logic               err_q, err_next;
  logic               fast_q, fast_next, fast_new;
  logic [CNT_W-1:0]   cnt, cnt_next;
  logic [31:0]        rdata_q, rdata_next;
  logic [N_SLAVES-1:0] req_next;
  logic [SEL_W-1:0]   sel;
  logic               mapped;
  logic [31:0]        sel_word;
  logic               sel_ack;
  logic               timeout;
  logic               err_log;

  assign sel     = mem_la_addr[31:SEL_LSB];
  assign mapped  = (33'(sel) >= 33'(BASE_SEL)) &&
                   (33'(sel) <  33'(BASE_SEL) + 33'(N_SLAVES));
  assign idx_new = IDX_W'(33'(sel) - 33'(BASE_SEL));
  assign timeout = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);

  // Loop-based selection keeps out-of-range (unmapped) indices harmless.
  always_comb begin
    fast_new = 1'b0;
    sel_word = '0;
    sel_ack  = 1'b0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (idx_new == IDX_W'(i)) fast_new = FAST_MASK[i];
      if (idx_q == IDX_W'(i)) begin
        sel_word = slave_rdata[32*i +: 32];
        sel_ack  = slave_ack[i];
      end
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = idx_q;
    addr_next  = addr_q;
    err_next   = err_q;
    fast_next  = fast_q;
    cnt_next   = cnt;
    rdata_next = rdata_q;
    case (state)
      IDLE: begin
        cnt_next = '0;
        if (mem_valid) begin
          idx_next   = idx_new;
          addr_next  = mem_la_addr;
          err_next   = !mapped;
          fast_next  = mapped && fast_new;
          state_next = (!mapped || fast_new) ? DONE : WAIT;
        end
      end
      WAIT: begin
        if (!mem_valid) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (sel_ack) begin
          rdata_next = sel_word;
          state_next = DONE;
        end else if (timeout) begin
          err_next   = 1'b1;
          state_next = DONE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      DONE: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_next = '0;
    if (state_next == WAIT) begin
      for (int unsigned i = 0; i < N_SLAVES; i++) begin
        if (idx_next == IDX_W'(i)) req_next[i] = 1'b1;
      end
    end
  end

  assign err_log = (state_next == DONE) && err_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      err_q     <= 1'b0;
      fast_q    <= 1'b0;
      cnt       <= '0;
      rdata_q   <= '0;
      slave_req <= '0;
      mem_ready <= 1'b0;
      bus_error <= 1'b0;
      err_addr  <= '0;
      err_count <= '0;
    end else begin
      state     <= state_next;
      idx_q     <= idx_next;
      addr_q    <= addr_next;
      err_q     <= err_next;
      fast_q    <= fast_next;
      cnt       <= cnt_next;
      rdata_q   <= rdata_next;
      slave_req <= req_next;
      mem_ready <= (state_next == DONE);
      bus_error <= err_log;
      if (err_log) begin
        err_addr <= addr_next;
        if (err_count != '1) err_count <= err_count + 8'd1;
      end
    end
  end

  // Fast slaves present data live during DONE; handshaked data was captured on ack.
  always_comb begin
    mem_rdata = '0;
    if (state == DONE) begin
      if (err_q)       mem_rdata = ERROR_DATA;
      else if (fast_q) mem_rdata = sel_word;
      else             mem_rdata = rdata_q;
    end
  end

endmodule

// File: tb/tb_picorv_bus_fabric.sv
// Directed self-checking bench for picorv_bus_fabric (TIMEOUT_CYCLES=16).
module tb_picorv_bus_fabric;

  logic           clk = 1'b0;
  logic           reset;
  logic           mem_valid;
  logic [31:0]    mem_la_addr;
  logic           mem_ready;
  logic [31:0]    mem_rdata;
  logic [5:0]     slave_req;
  logic [5:0]     slave_ack;
  logic [191:0]   slave_rdata;
  logic           bus_error;
  logic [31:0]    err_addr;
  logic [7:0]     err_count;

  int n_cmp = 0;
  int n_err = 0;

  picorv_bus_fabric #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_la_addr(mem_la_addr),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata), .slave_req(slave_req),
    .slave_ack(slave_ack), .slave_rdata(slave_rdata), .bus_error(bus_error),
    .err_addr(err_addr), .err_count(err_count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: observed no finish, expected finish before 300000ns");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one ch4 transaction with no ack; checks it completes within a bound.
  task automatic run_timeout_txn();
    logic seen;
    seen = 1'b0;
    mem_la_addr = 32'h5000_0000;
    mem_valid   = 1'b1;
    for (int k = 0; k < 40 && !seen; k++) begin
      tick();
      if (mem_ready) seen = 1'b1;
    end
    check("sat_ready_seen", {31'd0, seen}, 32'd1);
    mem_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset       = 1'b1;
    mem_valid   = 1'b0;
    mem_la_addr = '0;
    slave_ack   = '0;
    slave_rdata = '0;
    slave_rdata[0*32 +: 32] = 32'h1234_5678;
    slave_rdata[1*32 +: 32] = 32'h1111_2222;
    tick(); tick();
    check("rst_ready", {31'd0, mem_ready}, 32'd0);
    check("rst_req", {26'd0, slave_req}, 32'd0);
    check("rst_buserr", {31'd0, bus_error}, 32'd0);
    check("rst_erraddr", err_addr, 32'd0);
    check("rst_errcnt", {24'd0, err_count}, 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    reset = 1'b0;
    tick();

    // Fast channel 0
    mem_la_addr = 32'h1000_0004;
    mem_valid   = 1'b1;
    tick();
    check("fast_ready", {31'd0, mem_ready}, 32'd1);
    check("fast_rdata", mem_rdata, 32'h1234_5678);
    check("fast_req", {26'd0, slave_req}, 32'd0);
    check("fast_buserr", {31'd0, bus_error}, 32'd0);
    mem_valid = 1'b0;
    tick();
    check("fast_ready_drop", {31'd0, mem_ready}, 32'd0);
    check("fast_rdata_idle", mem_rdata, 32'd0);

    // Handshaked channel 5, ack in 7th request cycle
    mem_la_addr = 32'h6000_0000;
    mem_valid   = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      check("hs_req", {26'd0, slave_req}, 32'h20);
      check("hs_ready_low", {31'd0, mem_ready}, 32'd0);
    end
    slave_ack[5] = 1'b1;
    slave_rdata[5*32 +: 32] = 32'hCAFE_F00D;
    tick();
    slave_ack[5] = 1'b0;
    slave_rdata[5*32 +: 32] = 32'h0;
    #1;
    check("hs_ready", {31'd0, mem_ready}, 32'd1);
    check("hs_rdata", mem_rdata, 32'hCAFE_F00D);
    check("hs_req_drop", {26'd0, slave_req}, 32'd0);
    check("hs_buserr", {31'd0, bus_error}, 32'd0);
    mem_valid = 1'b0;
    tick();

    // Unmapped address
    mem_la_addr = 32'hF000_0000;
    mem_valid   = 1'b1;
    tick();
    check("unm_ready", {31'd0, mem_ready}, 32'd1);
    check("unm_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("unm_buserr", {31'd0, bus_error}, 32'd1);
    check("unm_erraddr", err_addr, 32'hF000_0000);
    check("unm_errcnt", {24'd0, err_count}, 32'd1);
    mem_valid = 1'b0;
    tick();
    check("unm_buserr_pulse", {31'd0, bus_error}, 32'd0);

    // Channel 4 timeout; an ack on channel 5 must not complete it
    mem_la_addr = 32'h5000_0000;
    mem_valid   = 1'b1;
    slave_ack   = 6'b100000;
    for (int k = 1; k <= 16; k++) begin
      tick();
      check("to_req", {26'd0, slave_req}, 32'h10);
      check("to_ready_low", {31'd0, mem_ready}, 32'd0);
    end
    tick();
    slave_ack = '0;
    check("to_req_drop", {26'd0, slave_req}, 32'd0);
    check("to_ready", {31'd0, mem_ready}, 32'd1);
    check("to_rdata", mem_rdata, 32'hDEAD_BEEF);
    check("to_buserr", {31'd0, bus_error}, 32'd1);
    check("to_erraddr", err_addr, 32'h5000_0000);
    check("to_errcnt", {24'd0, err_count}, 32'd2);
    mem_valid = 1'b0;
    tick(); tick(); tick();
    slave_ack[4] = 1'b1;
    tick();
    slave_ack[4] = 1'b0;
    check("late_ack_ready", {31'd0, mem_ready}, 32'd0);
    check("late_ack_req", {26'd0, slave_req}, 32'd0);
    check("late_ack_errcnt", {24'd0, err_count}, 32'd2);

    // Ack on the exact timeout cycle wins
    mem_la_addr = 32'h5000_0000;
    mem_valid   = 1'b1;
    for (int k = 1; k <= 16; k++) tick();
    check("edge_req", {26'd0, slave_req}, 32'h10);
    slave_ack[4] = 1'b1;
    slave_rdata[4*32 +: 32] = 32'h0BAD_C0DE;
    tick();
    slave_ack[4] = 1'b0;
    check("edge_ready", {31'd0, mem_ready}, 32'd1);
    check("edge_buserr", {31'd0, bus_error}, 32'd0);
    check("edge_rdata", mem_rdata, 32'h0BAD_C0DE);
    check("edge_errcnt", {24'd0, err_count}, 32'd2);
    mem_valid = 1'b0;
    tick();

    // Saturation: 300 more timeout errors
    for (int i = 0; i < 300; i++) begin
      run_timeout_txn();
      if (i == 251) check("sat_errcnt_254", {24'd0, err_count}, 32'd254);
    end
    check("sat_errcnt_255", {24'd0, err_count}, 32'd255);

    // Reset pulsed mid-WAIT
    mem_la_addr = 32'h6000_0000;
    mem_valid   = 1'b1;
    tick(); tick(); tick();
    check("rmid_req", {26'd0, slave_req}, 32'h20);
    #2;
    reset = 1'b1;
    #1;
    check("rmid_req_async", {26'd0, slave_req}, 32'd0);
    check("rmid_ready_async", {31'd0, mem_ready}, 32'd0);
    check("rmid_errcnt", {24'd0, err_count}, 32'd0);
    mem_valid = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    mem_la_addr = 32'h2000_0000;
    mem_valid   = 1'b1;
    tick();
    check("post_rst_ready", {31'd0, mem_ready}, 32'd1);
    check("post_rst_rdata", mem_rdata, 32'h1111_2222);
    mem_valid = 1'b0;
    tick();

    // Decode boundaries: selector one above the last channel, and selector 0
    mem_la_addr = 32'h7000_0000;
    mem_valid   = 1'b1;
    tick();
    check("hi_bound_buserr", {31'd0, bus_error}, 32'd1);
    check("hi_bound_errcnt", {24'd0, err_count}, 32'd1);
    mem_valid = 1'b0;
    tick();
    mem_la_addr = 32'h0000_0010;
    mem_valid   = 1'b1;
    tick();
    check("lo_bound_buserr", {31'd0, bus_error}, 32'd1);
    check("lo_bound_erraddr", err_addr, 32'h0000_0010);
    check("lo_bound_errcnt", {24'd0, err_count}, 32'd2);
    mem_valid = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/picorv_bus_fabric.md
Name: picorv_bus_fabric

Overview:
- Parametrised successor to the hard-coded PicoRV32 memory-selector logic.
- Decodes mem_la_addr into N_SLAVES channels and runs a per-channel req/ack handshake. Each channel is either fast (fixed 1-cycle) or handshaked, set by FAST_MASK.
- Multiplexes read data and generates a registered mem_ready.
- Adds behaviour the old logic lacked: unmapped-address and timeout bus errors, an error data word, and error logging (address plus saturating count). Sits between the CPU core and all peripherals/memories.

Parameters:
- N_SLAVES, 6, number of slave channels (1..16).
- SEL_LSB, 28, lowest address bit of the selector field mem_la_addr[31:SEL_LSB].
- BASE_SEL, 1, selector value mapped to channel 0; channel i is at BASE_SEL+i.
- FAST_MASK, 6'b001111, bit i=1 means channel i is fast (no ack, ready next cycle).
- TIMEOUT_CYCLES, 1024, WAIT-state cycles before a timeout error; 0 disables timeout.
- ERROR_DATA, 32'hDEADBEEF, read data returned on any bus error.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- mem_valid  in  1  CPU transaction valid
- mem_la_addr  in  32  CPU look-ahead address
- mem_ready  out  1  registered transaction-complete strobe to CPU
- mem_rdata  out  32  read data to CPU
- slave_req  out  N_SLAVES  registered request, handshaked channels only
- slave_ack  in  N_SLAVES  per-channel acknowledge
- slave_rdata  in  32*N_SLAVES  channel i read data at bits [32*i+31:32*i]
- bus_error  out  1  one-cycle pulse, coincident with mem_ready, on error completion
- err_addr  out  32  address of the most recent errored transaction
- err_count  out  8  saturating count of errors

Behaviour:
- Reset (async, active-high): state=IDLE; mem_ready=0; slave_req=0; bus_error=0; err_addr=0; err_count=0; timeout counter=0; latched index/err flag=0.
- sel = mem_la_addr[31:SEL_LSB]; idx = sel-BASE_SEL; mapped iff BASE_SEL <= sel < BASE_SEL+N_SLAVES.
- States: IDLE, WAIT, DONE.
- IDLE with mem_valid=1: latch idx, address and mapped flag, then:
  - unmapped -> DONE with err=1;
  - fast channel -> DONE;
  - handshaked channel -> WAIT, with slave_req[idx]=1 from the next cycle.
- Fast latency: mem_ready=1 exactly one cycle after mem_valid first seen.
- WAIT:
  - timeout counter increments each cycle; slave_req[idx] held high.
  - slave_ack[idx]=1 -> capture slave_rdata[idx], drop req, go DONE.
  - counter reaches TIMEOUT_CYCLES with no ack -> drop req, DONE with err=1.
  - ack and timeout in the same cycle: ack wins, no error.
  - mem_valid low in WAIT (aborted by CPU) -> drop req, IDLE, no mem_ready, no error.
- DONE: exactly one cycle; mem_ready=1, bus_error=err, then IDLE. The counter clears on entry to IDLE.
- mem_rdata:
  - DONE with err: ERROR_DATA.
  - DONE, fast channel: live slave_rdata[idx]; the slave presents data the cycle after valid.
  - DONE, handshaked channel: the captured word.
  - Otherwise: 0.
- On error entry to DONE: err_addr <= latched address; err_count increments and saturates at 255 (no wrap).
- Only slave_ack of the latched idx is observed. Acks on other channels, and acks in IDLE/DONE (late acks after timeout), are ignored.
- At most one slave_req bit is high at any time. Fast channels' req bits are always 0.
- Writes: the fabric only sequences the handshake. Slaves take mem_wdata/mem_wstrb directly and qualify them with their own select.

Test Plan:
- Fast channel 0 read, addr 0x1000_0004, slave_rdata0=0x12345678 -> mem_ready high in cycle 1 only, mem_rdata=0x12345678, slave_req=0, bus_error=0.
- Handshaked channel 5 (addr 0x6000_0000), ack after 7 cycles with 0xCAFEF00D -> slave_req[5] high cycles 1..7, mem_ready in cycle 8, mem_rdata=0xCAFEF00D.
- Unmapped addr 0xF000_0000 -> mem_ready in cycle 1, mem_rdata=0xDEADBEEF, bus_error pulse, err_addr=0xF000_0000, err_count=1.
- Channel 4, no ack, TIMEOUT_CYCLES=16 -> req dropped after 16 WAIT cycles, ready with 0xDEADBEEF, bus_error=1. A late ack 3 cycles later is ignored. 300 such errors -> err_count=255.
- Ack asserted on the exact timeout cycle -> normal completion, bus_error=0, err_count unchanged.
- reset pulsed mid-WAIT -> slave_req=0, mem_ready=0 immediately (async), state IDLE. The next transaction completes normally.
